mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Sits directly upstream of the single-port Memory block. Arbitrates an instruction-fetch
//  port (read-only) and a data port (read/write) onto the one addr/data/we/q interface.
//  Sequences each access to Memory's 1-cycle synchronous read and returns results over a
//  req/ack handshake. Fixed data-over-fetch priority, with a starvation guard for fetch.
// PARAMETERS
//  DW            16  data width; matches Memory data/q
//  AW            16  address width; matches Memory addr
//  STARVE_LIMIT  4   max consecutive data grants while if_req is high (>=1)
// PORTS
//  clk       in   1   single clock, rising edge
//  rst_n     in   1   reset, asynchronous assert, active-low
//  if_req    in   1   fetch request; held with if_addr until if_ack
//  if_addr   in   AW  fetch word address
//  if_ack    out  1   one-cycle pulse; if_rdata valid in the same cycle
//  if_rdata  out  DW  fetched word; holds its value until the next fetch ack
//  d_req     in   1   data request; held with d_we/d_addr/d_wdata until d_ack
//  d_we      in   1   1 = write, 0 = read
//  d_addr    in   AW  data word address
//  d_wdata   in   DW  write data
//  d_ack     out  1   one-cycle pulse; d_rdata valid in the same cycle (reads only)
//  d_rdata   out  DW  read data; unchanged by writes
//  mem_addr  out  AW  to Memory.addr (registered)
//  mem_data  out  DW  to Memory.data (registered)
//  mem_we    out  1   to Memory.we (registered)
//  mem_q     in   DW  from Memory.q; valid 1 cycle after mem_addr is stable
//  busy      out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; mem_addr, mem_data, mem_we, if_ack, d_ack, if_rdata,
//   d_rdata, busy and streak all clear to 0 immediately. An in-flight access is dropped
//   with no ack; the requester re-issues it after reset.
//  FSM, 4 states, one cycle each except IDLE:
//   IDLE : if neither req is high, stay. Otherwise pick a winner, register mem_addr,
//          mem_data (=d_wdata for writes, else 0), mem_we (=d_we if data won, else 0),
//          latch grant, go ISSUE.
//   ISSUE: mem_we is active here (writes commit on this edge); go WAIT.
//   WAIT : mem_we<=0; mem_q is valid. Capture mem_q into the winner's rdata
//          (d_rdata not touched on writes); go RESP.
//   RESP : the winner's ack=1 for exactly this cycle; go IDLE.
//  Latency: from req sampled in IDLE to ack is 4 cycles; throughput is 1 access / 4 cycles.
//  Requesters may change req/addr on the edge that ends RESP. IDLE never samples a req that
//   was already served, so there is no double service.
//  Arbitration in IDLE:
//   - Data wins unless (if_req && streak==STARVE_LIMIT).
//   - streak increments on a data grant while if_req=1, saturating at STARVE_LIMIT.
//   - streak clears on a fetch grant, or on a data grant with if_req=0.
//  Never both acks in the same cycle. mem_we is never high outside ISSUE.
//  A req dropped before its ack is illegal. The arbiter still completes the access.
// STRUCTURE
//  Package misc_v_mem_pkg holds:
//   - DW and AW defaults
//   - typedef enum {IDLE, ISSUE, WAIT, RESP} arb_state_t
//   - typedef enum {GNT_IF, GNT_D} arb_grant_t
//  One sub-module, mem_arb_pick: combinational winner select plus the registered streak
//   counter ($clog2(STARVE_LIMIT+1) bits).
//  The top level holds the FSM, the memory-side registers and the rdata/ack registers.
// TESTING (bench instantiates mem_port_arbiter + Memory)
//  1 Reset: hold rst_n=0 mid-run -> all outputs 0 that cycle, busy=0, no ack after release.
//  2 Write/read: d_we=1, d_addr=0x0000, d_wdata=0x1111 -> mem_we=1 only in cycle 2, d_ack in
//    cycle 4. Then d_we=0 at 0x0000 -> d_rdata=0x1111 with d_ack.
//  3 Read leaves memory intact: d_we=0, d_addr=0x0001, d_wdata=0x2222 -> mem_we stays 0, and a
//    later read of 0x0001 returns the old word, not 0x2222.
//  4 Collision: if_req (0x0001) and d_req (write 0x3333 to 0x0001) rise in the same cycle ->
//    d_ack in cycle 4, if_ack in cycle 8, if_rdata=0x3333.
//  5 Starvation: d_req held with 6 back-to-back reads, if_req held -> exactly 4 d_acks, then
//    an if_ack, then the remaining d_acks.
//  6 Reset in WAIT of a fetch -> no if_ack. The re-issued fetch acks 4 cycles after release.

Source files
------------

// File: rtl/misc_v_mem_pkg.sv
// rtl/misc_v_mem_pkg.sv - shared widths and FSM/grant types for the memory port arbiter
package misc_v_mem_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic {GNT_IF, GNT_D} arb_grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of the memory port arbiter
interface mem_port_arbiter_if
    import misc_v_mem_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) ();

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [DW-1:0] mem_q;
    logic          busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_data, mem_we, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_data, mem_we, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - data-over-fetch winner select with a fetch starvation counter
module mem_arb_pick
    import misc_v_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req,
    input  logic       d_req,
    input  logic       en,
    output arb_grant_t grant
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] streak;

    always_comb begin
        grant = GNT_IF;
        if (d_req && !(if_req && streak == LIMIT)) begin
            grant = GNT_D;
        end
    end

    // Only data grants made while fetch is waiting count towards starvation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (en) begin
            if (grant == GNT_D && if_req) begin
                if (streak != LIMIT) begin
                    streak <= streak + 1'b1;
                end
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter sequencing accesses onto a 1-cycle sync-read memory
module mem_port_arbiter
    import misc_v_mem_pkg::*;
#(
    parameter int DW           = DW_DEF,
    parameter int AW           = AW_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    arb_state_t    state, state_nxt;
    arb_grant_t    pick, grant;
    logic          pick_en;
    logic          wr;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_data_r;
    logic          mem_we_r;
    logic          if_ack_r, d_ack_r;
    logic [DW-1:0] if_rdata_r, d_rdata_r;

    assign pick_en = (state == IDLE) && (bus.if_req || bus.d_req);

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (bus.if_req),
        .d_req  (bus.d_req),
        .en     (pick_en),
        .grant  (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_en) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Acks are set leaving WAIT so they coincide with the captured rdata in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= GNT_IF;
            wr         <= 1'b0;
            mem_addr_r <= '0;
            mem_data_r <= '0;
            mem_we_r   <= 1'b0;
            if_ack_r   <= 1'b0;
            d_ack_r    <= 1'b0;
            if_rdata_r <= '0;
            d_rdata_r  <= '0;
        end else begin
            if_ack_r <= 1'b0;
            d_ack_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_en) begin
                        grant <= pick;
                        if (pick == GNT_D) begin
                            wr         <= bus.d_we;
                            mem_addr_r <= bus.d_addr;
                            mem_we_r   <= bus.d_we;
                            mem_data_r <= bus.d_we ? bus.d_wdata : '0;
                        end else begin
                            wr         <= 1'b0;
                            mem_addr_r <= bus.if_addr;
                            mem_we_r   <= 1'b0;
                            mem_data_r <= '0;
                        end
                    end
                end
                ISSUE: mem_we_r <= 1'b0;
                WAIT: begin
                    if (grant == GNT_D) begin
                        if (!wr) begin
                            d_rdata_r <= bus.mem_q;
                        end
                        d_ack_r <= 1'b1;
                    end else begin
                        if_rdata_r <= bus.mem_q;
                        if_ack_r   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_data = mem_data_r;
    assign bus.mem_we   = mem_we_r;
    assign bus.if_ack   = if_ack_r;
    assign bus.d_ack    = d_ack_r;
    assign bus.if_rdata = if_rdata_r;
    assign bus.d_rdata  = d_rdata_r;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench: arbiter plus behavioural sync-read memory
module tb_mem_port_arbiter;
    import misc_v_mem_pkg::*;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [15:0] last_d_rd = 16'h0000;
    logic [15:0] mem [0:255];
    exp_t if_q[$];
    exp_t d_q[$];
    vec_t tbl[9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.DW(16), .AW(16), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        bus.mem_q <= mem[bus.mem_addr[7:0]];
        if (bus.mem_we) mem[bus.mem_addr[7:0]] = bus.mem_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus.if_ack && bus.d_ack) check("both_acks", 1, 0);
            if (bus.if_ack) begin
                if (if_q.size() == 0) check("if_unexpected_ack", 1, 0);
                else begin
                    e = if_q.pop_front();
                    check("if_ack_cycle", cyc, e.due);
                    check("if_rdata", bus.if_rdata, e.rdata);
                end
            end
            if (bus.d_ack) begin
                if (d_q.size() == 0) check("d_unexpected_ack", 1, 0);
                else begin
                    e = d_q.pop_front();
                    check("d_ack_cycle", cyc, e.due);
                    check("d_rdata", bus.d_rdata, e.rdata);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that ends RESP.
    task automatic do_access(input vec_t v, input bit chk_we);
        exp_t       e;
        logic [3:0] wep;
        bit         got;
        e.due = cyc + v.lat - 1;
        if (v.is_d) begin
            e.rdata = v.we ? last_d_rd : v.exp;
            if (!v.we) last_d_rd = v.exp;
            d_q.push_back(e);
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
        end else begin
            e.rdata = v.exp;
            if_q.push_back(e);
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end
        wep = 4'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (k < 4) wep[k] = bus.mem_we;
            got = v.is_d ? bus.d_ack : bus.if_ack;
        end
        if (!got) check(v.is_d ? "d_ack_timeout" : "if_ack_timeout", 1, 0);
        if (chk_we) check("mem_we_pattern", wep, v.we ? 4'b0010 : 4'b0000);
        @(posedge clk); #1;
        if (v.is_d) bus.d_req = 1'b0;
        else bus.if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t dv, fv;
        exp_t e;
        int   acks;
        bit   got;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        rst_n = 1'b0;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.if_ack, bus.d_ack, bus.if_rdata, bus.d_rdata, bus.mem_we}, 0);
        check("reset_bus", {bus.mem_addr, bus.mem_data}, 0);
        check("reset_busy", bus.busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        //            is_d we addr      wdata     exp       lat
        tbl[0] = '{1, 1, 16'h0000, 16'h1111, 16'h0000, 4};
        tbl[1] = '{1, 0, 16'h0000, 16'h0000, 16'h1111, 4};
        tbl[2] = '{1, 0, 16'h0001, 16'h2222, 16'hA001, 4};
        tbl[3] = '{1, 0, 16'h0001, 16'h0000, 16'hA001, 4};
        tbl[4] = '{0, 0, 16'h0000, 16'h0000, 16'h1111, 4};
        tbl[5] = '{0, 0, 16'h0002, 16'h0000, 16'hA002, 4};
        tbl[6] = '{1, 1, 16'h0005, 16'hBEEF, 16'h0000, 4};
        tbl[7] = '{0, 0, 16'h0005, 16'h0000, 16'hBEEF, 4};
        tbl[8] = '{1, 0, 16'h0005, 16'h0000, 16'hBEEF, 4};
        for (int i = 0; i < 9; i++) do_access(tbl[i], 1'b1);

        // Collision: data write wins, fetch then sees the new word.
        dv = '{1, 1, 16'h0001, 16'h3333, 16'h0000, 4};
        fv = '{0, 0, 16'h0001, 16'h0000, 16'h3333, 8};
        fork
            do_access(dv, 1'b0);
            do_access(fv, 1'b0);
        join

        // Starvation: four data grants, one fetch, then the remaining data.
        fork
            begin : dside
                vec_t sv;
                for (int i = 0; i < 6; i++) begin
                    sv = '{1, 0, 16'(8 + i), 16'h0000, 16'hA008 + 16'(i), (i == 4) ? 8 : 4};
                    do_access(sv, 1'b0);
                end
            end
            begin : fside
                vec_t sf;
                sf = '{0, 0, 16'h0020, 16'h0000, 16'hA020, 20};
                do_access(sf, 1'b0);
            end
        join

        // Mid-run reset during the ISSUE cycle of a data read; requester abandons it.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0003;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {bus.if_ack, bus.d_ack, bus.if_rdata, bus.d_rdata, bus.mem_we}, 0);
        check("midreset_bus", {bus.mem_addr, bus.mem_data}, 0);
        check("midreset_busy", bus.busy, 0);
        last_d_rd = 16'h0000;
        bus.d_req = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            acks += int'(bus.if_ack) + int'(bus.d_ack);
        end
        check("no_ack_after_reset", acks, 0);
        @(posedge clk); #1;

        // Reset in WAIT of a fetch, then re-issue after release.
        bus.if_req = 1'b1; bus.if_addr = 16'h0000;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("wait_reset_busy", bus.busy, 0);
        check("wait_reset_if_rdata", bus.if_rdata, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        e.rdata = 16'h1111;
        e.due   = cyc + 3;
        if_q.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bus.if_ack;
        end
        if (!got) check("reissue_timeout", 1, 0);
        @(posedge clk); #1;
        bus.if_req = 1'b0;

        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_empty", if_q.size() + d_q.size(), 0);
        check("idle_at_end", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
